// File: rtl/hazard_control_unit_if.sv
// Pipeline-side bundle for the hazard control unit: ID/EX and IF/ID operand
// info plus EX events come in, stall/flush controls and status go out.
interface hazard_control_unit_if #(
    parameter int CNT_W = 16
);
    // IF/ID instruction operands
    logic [4:0]       rs1_IFID;
    logic [4:0]       rs2_IFID;
    logic             uses_rs1_IFID;
    logic             uses_rs2_IFID;
    // ID/EX instruction destination info
    logic [4:0]       rd_IDEX;
    logic             RegWEn_IDEX;
    logic             is_load_IDEX;
    // EX-stage events
    logic             br_taken_EX;
    logic             mc_start_EX;
    logic             mc_done;
    logic             cnt_clear;
    // Pipeline controls
    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_stall;
    logic             idex_flush;
    // Status
    logic [1:0]       hz_state;
    logic [CNT_W-1:0] load_stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] mc_stall_cnt;
    logic             mc_timeout_err;

    // Pipeline side: supplies operand info/events, consumes controls
    modport master (
        output rs1_IFID, rs2_IFID, uses_rs1_IFID, uses_rs2_IFID,
               rd_IDEX, RegWEn_IDEX, is_load_IDEX,
               br_taken_EX, mc_start_EX, mc_done, cnt_clear,
        input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               hz_state, load_stall_cnt, flush_cnt, mc_stall_cnt, mc_timeout_err
    );

    // Hazard unit side
    modport slave (
        input  rs1_IFID, rs2_IFID, uses_rs1_IFID, uses_rs2_IFID,
               rd_IDEX, RegWEn_IDEX, is_load_IDEX,
               br_taken_EX, mc_start_EX, mc_done, cnt_clear,
        output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               hz_state, load_stall_cnt, flush_cnt, mc_stall_cnt, mc_timeout_err
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard control unit: detects load-use hazards, flushes on taken branches,
// holds the front end during multi-cycle EX ops, and keeps saturating
// performance counters plus a sticky multi-cycle timeout flag.
module hazard_control_unit #(
    parameter int CNT_W      = 16,
    parameter int MC_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    hazard_control_unit_if.slave  hif
);
    localparam int WAIT_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MC_WAIT = 2'd1
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]  mc_cnt_q, mc_cnt_d;

    logic load_use;
    logic ev_load, ev_flush, ev_mc;

    // Load-use: the IF/ID instruction reads the register a load in ID/EX is about to write
    always_comb begin
        load_use = hif.is_load_IDEX & hif.RegWEn_IDEX & (hif.rd_IDEX != 5'd0) &
                   ((hif.uses_rs1_IFID & (hif.rs1_IFID == hif.rd_IDEX)) |
                    (hif.uses_rs2_IFID & (hif.rs2_IFID == hif.rd_IDEX)));
    end

    // State and counter registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            wait_q      <= '0;
            err_q       <= 1'b0;
            load_cnt_q  <= '0;
            flush_cnt_q <= '0;
            mc_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            load_cnt_q  <= load_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mc_cnt_q    <= mc_cnt_d;
        end
    end

    // Next state: enter MC_WAIT on an unfinished multi-cycle op, leave on done or timeout
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        unique case (state_q)
            ST_RUN: begin
                if (!hif.br_taken_EX && hif.mc_start_EX && !hif.mc_done) begin
                    state_d = ST_MC_WAIT;
                    wait_d  = '0;
                end
            end
            ST_MC_WAIT: begin
                if (hif.mc_done) begin
                    state_d = ST_RUN;
                end else if (wait_q == WAIT_LAST) begin
                    // Forced release; the counter stops here rather than wrapping
                    state_d = ST_RUN;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Control outputs: same-cycle response, forced quiet while reset is high
    always_comb begin
        hif.pc_stall   = 1'b0;
        hif.ifid_stall = 1'b0;
        hif.ifid_flush = 1'b0;
        hif.idex_stall = 1'b0;
        hif.idex_flush = 1'b0;
        ev_load        = 1'b0;
        ev_flush       = 1'b0;
        ev_mc          = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ST_RUN: begin
                    if (hif.br_taken_EX) begin
                        hif.ifid_flush = 1'b1;
                        hif.idex_flush = 1'b1;
                        ev_flush       = 1'b1;
                    end else if (hif.mc_start_EX) begin
                        // A same-cycle mc_done means the op finished in one cycle
                        if (!hif.mc_done) begin
                            hif.pc_stall   = 1'b1;
                            hif.ifid_stall = 1'b1;
                            hif.idex_stall = 1'b1;
                            ev_mc          = 1'b1;
                        end
                    end else if (load_use) begin
                        hif.pc_stall   = 1'b1;
                        hif.ifid_stall = 1'b1;
                        hif.idex_flush = 1'b1;
                        ev_load        = 1'b1;
                    end
                end
                ST_MC_WAIT: begin
                    if (!hif.mc_done) begin
                        hif.pc_stall   = 1'b1;
                        hif.ifid_stall = 1'b1;
                        hif.idex_stall = 1'b1;
                        ev_mc          = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Performance counters: clear beats increment, saturate at all-ones
    always_comb begin
        load_cnt_d  = load_cnt_q;
        flush_cnt_d = flush_cnt_q;
        mc_cnt_d    = mc_cnt_q;
        if (hif.cnt_clear) begin
            load_cnt_d  = '0;
            flush_cnt_d = '0;
            mc_cnt_d    = '0;
        end else begin
            if (ev_load  && !(&load_cnt_q))  load_cnt_d  = load_cnt_q + 1'b1;
            if (ev_flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
            if (ev_mc    && !(&mc_cnt_q))    mc_cnt_d    = mc_cnt_q + 1'b1;
        end
    end

    // Status outputs straight from the registers
    always_comb begin
        hif.hz_state       = state_q;
        hif.load_stall_cnt = load_cnt_q;
        hif.flush_cnt      = flush_cnt_q;
        hif.mc_stall_cnt   = mc_cnt_q;
        hif.mc_timeout_err = err_q;
    end
endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: the driver applies a cycle of
// stimulus, predicts the DUT response from a cycle-level reference model and
// queues it; the monitor checks each queued prediction on the falling edge.
module tb_hazard_control_unit;
    localparam int CNT_W = 4;
    localparam int MCT   = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_control_unit_if #(.CNT_W(CNT_W)) hif ();

    hazard_control_unit #(.CNT_W(CNT_W), .MC_TIMEOUT(MCT)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
    );

    typedef struct {
        logic [4:0] ctrl;   // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush}
        int         st;
        int         lc, fc, mc;
        bit         err;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    bit m_busy = 0;
    int m_waited = 0;
    int m_lc = 0, m_fc = 0, m_mc = 0;
    bit m_err = 0;

    function automatic int sat_inc(int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // One cycle: drive inputs, predict outputs, advance model across the edge
    task automatic step(input string tag, input bit rst, input bit br, input bit mcs,
                        input bit done, input bit clr, input bit ld, input bit we,
                        input int rd, input int rs1, input int rs2,
                        input bit u1, input bit u2);
        exp_t e;
        bit lu, stall3, ldst, fl;
        @(posedge clk);
        #1;
        reset             = rst;
        hif.br_taken_EX   = br;
        hif.mc_start_EX   = mcs;
        hif.mc_done       = done;
        hif.cnt_clear     = clr;
        hif.is_load_IDEX  = ld;
        hif.RegWEn_IDEX   = we;
        hif.rd_IDEX       = 5'(rd);
        hif.rs1_IFID      = 5'(rs1);
        hif.rs2_IFID      = 5'(rs2);
        hif.uses_rs1_IFID = u1;
        hif.uses_rs2_IFID = u2;

        lu = ld && we && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        stall3 = 0; ldst = 0; fl = 0;
        if (!rst) begin
            if (m_busy) stall3 = !done;
            else if (br) fl = 1;
            else if (mcs) stall3 = !done;
            else if (lu) ldst = 1;
        end
        e.ctrl = {stall3 | ldst, stall3 | ldst, fl, stall3, fl | ldst};
        e.st = m_busy ? 1 : 0;
        e.lc = m_lc; e.fc = m_fc; e.mc = m_mc; e.err = m_err;
        e.tag = tag;
        exp_q.push_back(e);

        if (rst) begin
            m_busy = 0; m_waited = 0; m_lc = 0; m_fc = 0; m_mc = 0; m_err = 0;
        end else begin
            if (clr) begin
                m_lc = 0; m_fc = 0; m_mc = 0;
            end else begin
                if (ldst)   m_lc = sat_inc(m_lc);
                if (fl)     m_fc = sat_inc(m_fc);
                if (stall3) m_mc = sat_inc(m_mc);
            end
            if (m_busy) begin
                // Wait cycles numbered 0..MCT-1; the last unfinished one times out
                if (done) m_busy = 0;
                else if (m_waited == MCT - 1) begin m_busy = 0; m_err = 1; end
                else m_waited++;
            end else if (!br && mcs && !done) begin
                m_busy = 1; m_waited = 0;
            end
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string tag, input string what, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s/%s: got %0d expected %0d", tag, what, act, req);
        end
    endtask

    // Monitor: compare every predicted cycle against what the DUT presents
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.tag, "ctrl", int'({hif.pc_stall, hif.ifid_stall, hif.ifid_flush,
                                     hif.idex_stall, hif.idex_flush}), int'(e.ctrl));
            chk(e.tag, "state", int'(hif.hz_state), e.st);
            chk(e.tag, "load_cnt", int'(hif.load_stall_cnt), e.lc);
            chk(e.tag, "flush_cnt", int'(hif.flush_cnt), e.fc);
            chk(e.tag, "mc_cnt", int'(hif.mc_stall_cnt), e.mc);
            chk(e.tag, "err", int'(hif.mc_timeout_err), int'(e.err));
        end
    end

    initial begin
        hif.br_taken_EX = 0; hif.mc_start_EX = 0; hif.mc_done = 0; hif.cnt_clear = 0;
        hif.is_load_IDEX = 0; hif.RegWEn_IDEX = 0; hif.rd_IDEX = 0;
        hif.rs1_IFID = 0; hif.rs2_IFID = 0; hif.uses_rs1_IFID = 0; hif.uses_rs2_IFID = 0;

        // Reset state, with hazards present to prove outputs stay quiet
        step("reset", 1, 0, 0, 0, 0, 1, 1, 5, 5, 0, 1, 0);
        step("reset", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load-use on rs1, then the load moves on
        step("lu_rs1", 0, 0, 0, 0, 0, 1, 1, 5, 5, 0, 1, 0);
        idle("lu_after", 1);
        // rd = x0 never stalls; rs2 match does; unused operand does not
        step("lu_rd0", 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1);
        step("lu_rs2", 0, 0, 0, 0, 0, 1, 1, 7, 1, 7, 0, 1);
        step("lu_nouse", 0, 0, 0, 0, 0, 1, 1, 7, 7, 7, 0, 0);
        step("lu_nowe", 0, 0, 0, 0, 0, 1, 0, 7, 7, 7, 1, 1);

        // Branch beats load-use
        step("br_lu", 0, 1, 0, 0, 0, 1, 1, 5, 5, 0, 1, 0);
        idle("br_after", 1);

        // Multi-cycle op finishing four cycles after start
        step("mc_start", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("mc_wait", 0, 1, 1, 0, 0, 1, 1, 5, 5, 0, 1, 0);
        idle("mc_wait", 2);
        step("mc_done", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Single-cycle completion
        step("mc_1cyc", 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Timeout, then error stays sticky
        step("to_start", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("to_wait", MCT);
        idle("to_after", 3);
        step("to_clr", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

        // Saturation of the load-use counter, then clear beating an increment
        for (int i = 0; i < 20; i++) begin
            step("sat", 0, 0, 0, 0, 0, 1, 1, 3, 3, 0, 1, 0);
            idle("sat_gap", 1);
        end
        step("clr_hz", 0, 0, 0, 0, 1, 1, 1, 3, 3, 0, 1, 0);
        idle("clr_after", 1);

        // Reset in the middle of MC_WAIT
        step("rmc_start", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("rmc_wait", 2);
        step("rmc_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("rmc_after", 2);

        // Random traffic with small register numbers to hit matches often
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 ($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 12),
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 2),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 1));
        end

        // Let the monitor drain, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
